// File: rtl/fas_peak_analyzer_if.sv
// Frame input and peak-report output bundle for fas_peak_analyzer.
// fft_d[k] carries bin k as {re, im}, each signed DW-bit fixed point.
interface fas_peak_analyzer_if #(
    parameter int NBIN = 16,
    parameter int DW   = 16
);
    logic                        fft_valid;
    logic [NBIN-1:0][2*DW-1:0]   fft_d;
    logic                        done;
    logic [$clog2(NBIN)-1:0]     freq;
    logic [2*DW-1:0]             peak_mag;
    logic                        busy;
    logic                        overrun;

    modport master (output fft_valid, fft_d, input done, freq, peak_mag, busy, overrun);
    modport slave  (input fft_valid, fft_d, output done, freq, peak_mag, busy, overrun);
endinterface

// File: rtl/fas_peak_analyzer.sv
// Peak-bin analyzer: scans a captured 16-bin spectrum one bin per clock and reports the max-power bin.
// Define ANA_SKIP_DC_EN to exclude bin 0 from the search (scan starts at bin 1).
module fas_peak_analyzer #(
    parameter int NBIN = 16,
    parameter int DW   = 16
) (
    input  logic                clk,
    input  logic                rst,
    fas_peak_analyzer_if.slave  bus
);
    localparam int IW = $clog2(NBIN);
    localparam int BW = 2 * DW;
`ifdef ANA_SKIP_DC_EN
    localparam logic [IW-1:0] START = IW'(1);
`else
    localparam logic [IW-1:0] START = '0;
`endif
    localparam logic [IW-1:0] LAST = IW'(NBIN - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

    state_t                  r_state;
    logic [NBIN-1:0][BW-1:0] r_work;
    logic [NBIN-1:0][BW-1:0] r_pend;
    logic                    r_pend_vld;
    logic [IW-1:0]           r_idx;
    logic [BW-1:0]           r_mag_p0;
    logic [IW-1:0]           r_idx_p0;
    logic                    r_vld_p0;
    logic                    r_first_p0;
    logic                    r_last_p0;
    logic [BW-1:0]           r_max;
    logic [IW-1:0]           r_max_idx;
    logic                    r_done;
    logic [IW-1:0]           r_freq;
    logic [BW-1:0]           r_peak;
    logic                    r_overrun;
    logic                    w_take;
    logic [BW-1:0]           w_max_nx;
    logic [IW-1:0]           w_idx_nx;

    // Each square is at most 2^30, so the sum fits 32 bits unsigned without wrap.
    function automatic logic [BW-1:0] f_power(input logic [BW-1:0] bin);
        logic signed [BW-1:0] re;
        logic signed [BW-1:0] im;
        logic [BW-1:0]        p_re;
        logic [BW-1:0]        p_im;
        re   = {{DW{bin[BW-1]}}, bin[BW-1:DW]};
        im   = {{DW{bin[DW-1]}}, bin[DW-1:0]};
        p_re = re * re;
        p_im = im * im;
        return p_re + p_im;
    endfunction

    // First bin of a frame seeds the max; strict compare keeps the lowest index on ties.
    always_comb begin
        w_take   = r_first_p0 || (r_mag_p0 > r_max);
        w_max_nx = w_take ? r_mag_p0 : r_max;
        w_idx_nx = w_take ? r_idx_p0 : r_max_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= START;
            r_pend_vld <= 1'b0;
            r_vld_p0   <= 1'b0;
            r_done     <= 1'b0;
            r_freq     <= '0;
            r_peak     <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_vld_p0 <= 1'b0;
            // p0 -> compare stage: fold one bin power into the running max
            if (r_vld_p0) begin
                r_max     <= w_max_nx;
                r_max_idx <= w_idx_nx;
                if (r_last_p0) begin
                    r_done <= 1'b1;
                    r_freq <= w_idx_nx;
                    r_peak <= w_max_nx;
                end
            end
            case (r_state)
                IDLE, DRAIN, REPORT: begin
                    if (bus.fft_valid) begin
                        r_work  <= bus.fft_d;
                        r_idx   <= START;
                        r_state <= SCAN;
                    end else begin
                        r_state <= (r_state == DRAIN) ? REPORT : IDLE;
                    end
                end
                SCAN: begin
                    r_vld_p0   <= 1'b1;
                    r_mag_p0   <= f_power(r_work[r_idx]);
                    r_idx_p0   <= r_idx;
                    r_first_p0 <= (r_idx == START);
                    r_last_p0  <= (r_idx == LAST);
                    if (r_idx == LAST) begin
                        // Last bin read: next frame starts now so frames every 16 clocks keep pace
                        r_idx <= START;
                        if (r_pend_vld) begin
                            r_work     <= r_pend;
                            r_pend_vld <= bus.fft_valid;
                            if (bus.fft_valid) r_pend <= bus.fft_d;
                        end else if (bus.fft_valid) begin
                            r_work <= bus.fft_d;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        if (bus.fft_valid) begin
                            r_pend     <= bus.fft_d;
                            r_pend_vld <= 1'b1;
                            if (r_pend_vld) r_overrun <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.done     = r_done;
    assign bus.freq     = r_freq;
    assign bus.peak_mag = r_peak;
    assign bus.busy     = (r_state != IDLE) || r_pend_vld;
    assign bus.overrun  = r_overrun;
endmodule

// File: tb/tb_fas_peak_analyzer.sv
// Bench for fas_peak_analyzer: directed vector table, hand sequences and random frames
// checked every cycle against a frame-level scheduling/argmax model.
`timescale 1ns/1ps
module tb_fas_peak_analyzer;
    localparam int NBIN = 16;
`ifdef ANA_SKIP_DC_EN
    localparam int FIRST = 1;
    localparam logic [3:0]  DC_FREQ = 4'd5;
    localparam logic [31:0] DC_PEAK = 32'h0000_0100;
`else
    localparam int FIRST = 0;
    localparam logic [3:0]  DC_FREQ = 4'd0;
    localparam logic [31:0] DC_PEAK = 32'h3FFF_0001;
`endif
    localparam int P = NBIN - FIRST;

    typedef logic [NBIN-1:0][31:0] frame_t;
    typedef struct { int due; logic [3:0] freq; logic [31:0] peak; } exp_t;
    typedef struct {
        int ia; logic [31:0] va; int ib; logic [31:0] vb;
        logic [3:0] efreq; logic [31:0] epeak;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fas_peak_analyzer_if #(.NBIN(NBIN), .DW(16)) bus ();
    fas_peak_analyzer #(.NBIN(NBIN), .DW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        q[$];
    int          last_load;
    bit          pend_v;
    exp_t        pend_e;
    bit          m_ovr;
    logic [3:0]  m_freq;
    logic [31:0] m_peak;
    logic [3:0]  obs_freq[$];
    logic [31:0] obs_peak[$];

    function automatic longint power(input logic [31:0] b);
        longint re, im;
        re = longint'($signed(b[31:16]));
        im = longint'($signed(b[15:0]));
        return re * re + im * im;
    endfunction

    function automatic exp_t analyse(input frame_t f);
        exp_t e;
        int   best;
        best = FIRST;
        for (int k = FIRST + 1; k < NBIN; k++)
            if (power(f[k]) > power(f[best])) best = k;
        e.due  = 0;
        e.freq = 4'(best);
        e.peak = 32'(power(f[best]));
        return e;
    endfunction

    function automatic frame_t rnd_frame(input int mode);
        frame_t f;
        for (int k = 0; k < NBIN; k++) begin
            logic [15:0] re, im;
            case (mode)
                1: begin
                    re = 16'($urandom_range(0, 4)) - 16'd2;
                    im = 16'($urandom_range(0, 4)) - 16'd2;
                end
                2: begin
                    case ($urandom_range(0, 2))
                        0: re = 16'h8000;
                        1: re = 16'h7FFF;
                        default: re = 16'h0000;
                    endcase
                    im = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h0000;
                end
                default: begin
                    re = 16'($urandom);
                    im = 16'($urandom);
                end
            endcase
            f[k] = {re, im};
        end
        return f;
    endfunction

    task automatic model_clear();
        q.delete();
        last_load = -1000;
        pend_v    = 1'b0;
        m_ovr     = 1'b0;
        m_freq    = '0;
        m_peak    = '0;
    endtask

    // A waiting frame starts as soon as the scanner finishes its current frame.
    task automatic model_advance(input int e);
        if (pend_v && (last_load + P <= e)) begin
            last_load  = last_load + P;
            pend_e.due = last_load + P + 1;
            q.push_back(pend_e);
            pend_v = 1'b0;
        end
    endtask

    task automatic model_arrive(input int a, input exp_t e);
        model_advance(a);
        if (a >= last_load + P) begin
            last_load = a;
            e.due     = a + P + 1;
            q.push_back(e);
        end else begin
            if (pend_v) m_ovr = 1'b1;
            pend_v = 1'b1;
            pend_e = e;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        bit   ed;
        bit   eb;
        exp_t tmp;
        @(posedge clk);
        cyc++;
        #1;
        if (rst) model_clear();
        model_advance(cyc);
        ed = (q.size() > 0) && (q[0].due == cyc);
        if (ed) begin
            tmp    = q.pop_front();
            m_freq = tmp.freq;
            m_peak = tmp.peak;
        end
        eb = pend_v || ((cyc >= last_load) && (cyc <= last_load + P + 1));
        if (bus.done) begin
            obs_freq.push_back(bus.freq);
            obs_peak.push_back(bus.peak_mag);
        end
        check("done", 32'(bus.done), 32'(ed));
        check("freq", 32'(bus.freq), 32'(m_freq));
        check("peak_mag", bus.peak_mag, m_peak);
        check("busy", 32'(bus.busy), 32'(eb));
        check("overrun", 32'(bus.overrun), 32'(m_ovr));
    endtask

    task automatic cycle_idle(input int n);
        repeat (n) begin
            bus.fft_valid = 1'b0;
            bus.fft_d     = rnd_frame(0);
            tick();
        end
    endtask

    task automatic send(input frame_t f);
        bus.fft_valid = 1'b1;
        bus.fft_d     = f;
        model_arrive(cyc + 1, analyse(f));
        tick();
        bus.fft_valid = 1'b0;
        bus.fft_d     = rnd_frame(0);
    endtask

    initial begin
        vec_t   vt[8];
        frame_t f;
        int     gap;

        model_clear();
        bus.fft_valid = 1'b0;
        bus.fft_d     = '0;

        vt[0] = '{1, 32'h0100_0000, 1, 32'h0100_0000, 4'd1, 32'h0001_0000};
        vt[1] = '{1, 32'h0080_0080, 15, 32'h0080_0080, 4'd1, 32'h0000_8000};
        vt[2] = '{7, 32'h8000_8000, 7, 32'h8000_8000, 4'd7, 32'h8000_0000};
        vt[3] = '{0, 32'h0, 0, 32'h0, 4'(FIRST), 32'h0};
        vt[4] = '{0, 32'h7FFF_0000, 5, 32'h0010_0000, DC_FREQ, DC_PEAK};
        vt[5] = '{3, 32'hFF00_0100, 12, 32'h0000_0180, 4'd12, 32'h0002_4000};
        vt[6] = '{9, 32'h0001_0000, 10, 32'h0000_FFFF, 4'd9, 32'h0000_0001};
        vt[7] = '{15, 32'h7FFF_7FFF, 2, 32'h8000_0000, 4'd15, 32'h7FFE_0002};

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        cycle_idle(5);

        foreach (vt[i]) begin
            f = '0;
            f[vt[i].ia] = vt[i].va;
            f[vt[i].ib] = vt[i].vb;
            obs_freq.delete();
            obs_peak.delete();
            send(f);
            for (int w = 0; w < 40 && obs_freq.size() == 0; w++) cycle_idle(1);
            if (obs_freq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL table_timeout vector %0d: no done within 40 cycles, expected freq %0d", i, vt[i].efreq);
            end else begin
                check("table_freq", 32'(obs_freq[0]), 32'(vt[i].efreq));
                check("table_peak", obs_peak[0], vt[i].epeak);
            end
            cycle_idle(3);
        end

        obs_freq.delete();
        for (int k = 0; k < 4; k++) begin
            f = '0;
            f[(k % 2 == 1) ? 15 : 1] = 32'h0100_0000;
            send(f);
            cycle_idle(15);
        end
        cycle_idle(20);
        check("stream_count", 32'(obs_freq.size()), 32'd4);
        if (obs_freq.size() == 4) begin
            check("stream_f0", 32'(obs_freq[0]), 32'd1);
            check("stream_f1", 32'(obs_freq[1]), 32'd15);
            check("stream_f2", 32'(obs_freq[2]), 32'd1);
            check("stream_f3", 32'(obs_freq[3]), 32'd15);
        end
        check("stream_overrun", 32'(bus.overrun), 32'd0);

        obs_freq.delete();
        for (int k = 2; k <= 4; k++) begin
            f = '0;
            f[k] = 32'h0100_0000;
            send(f);
        end
        cycle_idle(40);
        check("burst_count", 32'(obs_freq.size()), 32'd2);
        if (obs_freq.size() == 2) begin
            check("burst_f0", 32'(obs_freq[0]), 32'd2);
            check("burst_f1", 32'(obs_freq[1]), 32'd4);
        end
        check("burst_overrun", 32'(bus.overrun), 32'd1);

        obs_freq.delete();
        f = '0;
        f[6] = 32'h0100_0000;
        send(f);
        cycle_idle(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cycle_idle(30);
        check("abort_dones", 32'(obs_freq.size()), 32'd0);
        check("abort_overrun", 32'(bus.overrun), 32'd0);

        for (int n = 0; n < 250; n++) begin
            send(rnd_frame($urandom_range(0, 2)));
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(12, 20);
            cycle_idle(gap);
            if (n == 125) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        cycle_idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
